// File: rtl/portamento_sched_if.sv
// Bus bundle for portamento_sched: host config/pitch writes, the shared portamento
// datapath handshake, and the captured-output / status side.
interface portamento_sched_if #(
    parameter int unsigned NUNITS = 4,
    parameter int unsigned DSZ    = 52
);
    localparam int unsigned AW = (NUNITS > 1) ? $clog2(NUNITS) : 1;

    logic                  cfg_we;
    logic [AW-1:0]         cfg_addr;
    logic [17:0]           cfg_div;
    logic [2:0]            cfg_bw;

    logic                  pitch_we;
    logic [AW-1:0]         pitch_addr;
    logic signed [DSZ-1:0] pitch_data;

    logic [AW-1:0]         porta_unit;
    logic                  porta_clk;
    logic signed [DSZ-1:0] porta_in;
    logic [17:0]           porta_div;
    logic [2:0]            porta_bw;
    logic signed [DSZ-1:0] porta_out;

    logic [AW-1:0]         out_unit;
    logic signed [DSZ-1:0] out_data;
    logic                  out_valid;

    logic                  busy;
    logic                  overrun;
    logic                  ovr_clr;

    // master: host plus external datapath; slave: the scheduler
    modport master (
        output cfg_we, cfg_addr, cfg_div, cfg_bw,
        output pitch_we, pitch_addr, pitch_data,
        output porta_out, ovr_clr,
        input  porta_unit, porta_clk, porta_in, porta_div, porta_bw,
        input  out_unit, out_data, out_valid, busy, overrun
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_div, cfg_bw,
        input  pitch_we, pitch_addr, pitch_data,
        input  porta_out, ovr_clr,
        output porta_unit, porta_clk, porta_in, porta_div, porta_bw,
        output out_unit, out_data, out_valid, busy, overrun
    );
endinterface

// File: rtl/portamento_sched.sv
// Time-multiplexes NUNITS pitch channels through one portamento datapath, one sweep per tick.
// Optional sticky dropped-tick flag enabled by defining PORTA_SCHED_OVERRUN_EN.
module portamento_sched #(
    parameter int unsigned NUNITS   = 4,
    parameter int unsigned DSZ      = 52,
    parameter int unsigned PRESCALE = 50
) (
    input  logic              clk50mhz,
    input  logic              reset,
    portamento_sched_if.slave bus
);
    localparam int unsigned AW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DW = 18;
    localparam int unsigned BW = 3;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SELECT  = 2'd1;
    localparam logic [1:0] S_STROBE  = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    localparam logic [AW-1:0] LAST_UNIT = AW'(NUNITS - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);

    logic [PW-1:0]         r_pre;
    logic                  w_tick;
    logic [1:0]            r_state, w_state_nxt;
    logic [AW-1:0]         r_idx, w_idx_nxt;
    logic                  w_load, w_sel, w_strobe, w_cap;

    logic signed [DSZ-1:0] r_sh_pitch  [NUNITS];
    logic [DW-1:0]         r_sh_div    [NUNITS];
    logic [BW-1:0]         r_sh_bw     [NUNITS];
    logic signed [DSZ-1:0] r_act_pitch [NUNITS];
    logic [DW-1:0]         r_act_div   [NUNITS];
    logic [BW-1:0]         r_act_bw    [NUNITS];

    logic signed [DSZ-1:0] w_src_pitch;
    logic [DW-1:0]         w_src_div;
    logic [BW-1:0]         w_src_bw;

    logic [AW-1:0]         r_porta_unit;
    logic                  r_porta_clk;
    logic signed [DSZ-1:0] r_porta_in;
    logic [DW-1:0]         r_porta_div;
    logic [BW-1:0]         r_porta_bw;
    logic [AW-1:0]         r_out_unit;
    logic signed [DSZ-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_busy;

    // Tick prescaler
    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) r_pre <= '0;
        else       r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end

    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Ticks seen outside IDLE fall through unused: the sweep is never restarted
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_sel       = 1'b0;
        w_strobe    = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = S_SELECT;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            S_SELECT: begin
                w_state_nxt = S_STROBE;
                w_strobe    = 1'b1;
            end
            S_STROBE: w_state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                w_cap = 1'b1;
                if (r_idx == LAST_UNIT) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SELECT;
                    w_idx_nxt   = r_idx + AW'(1);
                    w_sel       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Unit 0 is taken from shadow because active is being loaded on the same edge
    always_comb begin
        if (w_load) begin
            w_src_pitch = r_sh_pitch[0];
            w_src_div   = r_sh_div[0];
            w_src_bw    = r_sh_bw[0];
        end else begin
            w_src_pitch = r_act_pitch[w_idx_nxt];
            w_src_div   = r_act_div[w_idx_nxt];
            w_src_bw    = r_act_bw[w_idx_nxt];
        end
    end

    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUNITS); i++) begin
                r_sh_pitch[i] <= '0;
                r_sh_div[i]   <= '0;
                r_sh_bw[i]    <= '0;
            end
        end else begin
            if (bus.cfg_we) begin
                r_sh_div[bus.cfg_addr] <= bus.cfg_div;
                r_sh_bw[bus.cfg_addr]  <= bus.cfg_bw;
            end
            if (bus.pitch_we) r_sh_pitch[bus.pitch_addr] <= bus.pitch_data;
        end
    end

    // Active set frozen for the whole sweep; a same-edge shadow write lands next sweep
    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUNITS); i++) begin
                r_act_pitch[i] <= '0;
                r_act_div[i]   <= '0;
                r_act_bw[i]    <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < int'(NUNITS); i++) begin
                r_act_pitch[i] <= r_sh_pitch[i];
                r_act_div[i]   <= r_sh_div[i];
                r_act_bw[i]    <= r_sh_bw[i];
            end
        end
    end

    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            r_porta_unit <= '0;
            r_porta_in   <= '0;
            r_porta_div  <= '0;
            r_porta_bw   <= '0;
            r_porta_clk  <= 1'b0;
            r_out_unit   <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (w_load || w_sel) begin
                r_porta_unit <= w_idx_nxt;
                r_porta_in   <= w_src_pitch;
                r_porta_div  <= w_src_div;
                r_porta_bw   <= w_src_bw;
            end
            r_porta_clk <= w_strobe;
            r_out_valid <= w_cap;
            if (w_cap) begin
                r_out_unit <= r_idx;
                r_out_data <= bus.porta_out;
            end
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef PORTA_SCHED_OVERRUN_EN
    logic w_drop;
    logic r_overrun;

    assign w_drop = w_tick && (r_state != S_IDLE);

    // Set wins over a simultaneous clear
    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset)            r_overrun <= 1'b0;
        else if (w_drop)      r_overrun <= 1'b1;
        else if (bus.ovr_clr) r_overrun <= 1'b0;
    end

    assign bus.overrun = r_overrun;
`else
    logic w_unused_ovr_clr;
    assign w_unused_ovr_clr = bus.ovr_clr;
    assign bus.overrun      = 1'b0;
`endif

    assign bus.porta_unit = r_porta_unit;
    assign bus.porta_clk  = r_porta_clk;
    assign bus.porta_in   = r_porta_in;
    assign bus.porta_div  = r_porta_div;
    assign bus.porta_bw   = r_porta_bw;
    assign bus.out_unit   = r_out_unit;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_portamento_sched.sv
// Scoreboard bench for portamento_sched: a sweep-level model queues expected strobes and
// captures, a negedge monitor pops and compares them. PRESCALE=12 so every other tick is dropped.
module tb_portamento_sched;
    localparam int unsigned NUNITS   = 4;
    localparam int unsigned DSZ      = 52;
    localparam int unsigned PRESCALE = 12;
    localparam int unsigned AW       = 2;

    typedef struct packed {
        int            g;
        logic [AW-1:0] u;
        logic [DSZ-1:0] pin;
        logic [17:0]   div;
        logic [2:0]    bw;
    } strobe_t;

    typedef struct packed {
        int            g;
        logic [AW-1:0] u;
        logic [DSZ-1:0] data;
    } cap_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    portamento_sched_if #(.NUNITS(NUNITS), .DSZ(DSZ)) bus ();

    portamento_sched #(.NUNITS(NUNITS), .DSZ(DSZ), .PRESCALE(PRESCALE)) dut (
        .clk50mhz (clk),
        .reset    (reset),
        .bus      (bus)
    );

    // Stand-in datapath: result depends on every field presented for the unit
    function automatic logic [DSZ-1:0] dp(input logic [AW-1:0] u, input logic [DSZ-1:0] pin,
                                          input logic [17:0] div, input logic [2:0] bw);
        return pin ^ (DSZ'(u) << 44) ^ (DSZ'(div) << 3) ^ DSZ'(bw) ^ DSZ'(52'h5A5A);
    endfunction

    assign bus.porta_out = dp(bus.porta_unit, bus.porta_in, bus.porta_div, bus.porta_bw);

    int n_tests = 0;
    int n_fail  = 0;

    strobe_t sq[$];
    cap_t    cq[$];

    logic [DSZ-1:0] m_pin [NUNITS];
    logic [17:0]    m_div [NUNITS];
    logic [2:0]     m_bw  [NUNITS];
    int  g       = 0;
    int  n_rel   = 0;
    int  m_start = 0;
    int  m_end   = -1;
    bit  m_ovr   = 1'b0;

    // Reference model: a sweep starts on every PRESCALE-th edge after reset unless one is running
    always @(posedge clk) begin
        bit dropped;
        g++;
        dropped = 1'b0;
        if (reset) begin
            n_rel = 0; m_start = 0; m_end = -1; m_ovr = 1'b0;
            sq.delete(); cq.delete();
            for (int i = 0; i < int'(NUNITS); i++) begin
                m_pin[i] = '0; m_div[i] = '0; m_bw[i] = '0;
            end
        end else begin
            n_rel++;
            if (n_rel % int'(PRESCALE) == 0) begin
                if (g > m_end) begin
                    m_start = g;
                    m_end   = g + 3 * int'(NUNITS);
                    for (int u = 0; u < int'(NUNITS); u++) begin
                        sq.push_back('{g + 1 + 3 * u, AW'(u), m_pin[u], m_div[u], m_bw[u]});
                        cq.push_back('{g + 3 + 3 * u, AW'(u), dp(AW'(u), m_pin[u], m_div[u], m_bw[u])});
                    end
                end else begin
                    dropped = 1'b1;
                end
            end
`ifdef PORTA_SCHED_OVERRUN_EN
            if (dropped)          m_ovr = 1'b1;
            else if (bus.ovr_clr) m_ovr = 1'b0;
`endif
            if (bus.cfg_we) begin
                m_div[bus.cfg_addr] = bus.cfg_div;
                m_bw[bus.cfg_addr]  = bus.cfg_bw;
            end
            if (bus.pitch_we) m_pin[bus.pitch_addr] = bus.pitch_data;
        end
    end

    strobe_t se;
    cap_t    ce;
    bit      exp_busy;

    // Monitor
    always @(negedge clk) begin
        if (reset) begin
            n_tests++;
            if (bus.porta_unit != '0 || bus.porta_clk || bus.porta_in != '0 || bus.porta_div != '0 ||
                bus.porta_bw != '0 || bus.out_unit != '0 || bus.out_data != '0 || bus.out_valid ||
                bus.busy || bus.overrun) begin
                n_fail++;
                $display("FAIL reset_zero t=%0t: clk=%b unit=%0d in=%h div=%h bw=%0d valid=%b busy=%b ovr=%b, required all 0",
                         $time, bus.porta_clk, bus.porta_unit, bus.porta_in, bus.porta_div, bus.porta_bw,
                         bus.out_valid, bus.busy, bus.overrun);
            end
        end else begin
            exp_busy = (g >= m_start) && (g < m_end);
            n_tests++;
            if (bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy g=%0d: got %b, required %b", g, bus.busy, exp_busy);
            end
            n_tests++;
            if (bus.overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL overrun g=%0d: got %b, required %b", g, bus.overrun, m_ovr);
            end
            if (bus.porta_clk || (sq.size() > 0 && sq[0].g == g)) begin
                n_tests++;
                if (sq.size() == 0) begin
                    n_fail++;
                    $display("FAIL strobe g=%0d: unexpected porta_clk unit=%0d, required none", g, bus.porta_unit);
                end else begin
                    se = sq.pop_front();
                    if (se.g != g || bus.porta_clk !== 1'b1 || bus.porta_unit != se.u ||
                        bus.porta_in != se.pin || bus.porta_div != se.div || bus.porta_bw != se.bw) begin
                        n_fail++;
                        $display("FAIL strobe g=%0d: clk=%b unit=%0d in=%h div=%h bw=%0d, required g=%0d unit=%0d in=%h div=%h bw=%0d",
                                 g, bus.porta_clk, bus.porta_unit, bus.porta_in, bus.porta_div, bus.porta_bw,
                                 se.g, se.u, se.pin, se.div, se.bw);
                    end
                end
            end
            if (bus.out_valid || (cq.size() > 0 && cq[0].g == g)) begin
                n_tests++;
                if (cq.size() == 0) begin
                    n_fail++;
                    $display("FAIL capture g=%0d: unexpected out_valid unit=%0d, required none", g, bus.out_unit);
                end else begin
                    ce = cq.pop_front();
                    if (ce.g != g || bus.out_valid !== 1'b1 || bus.out_unit != ce.u || bus.out_data != ce.data) begin
                        n_fail++;
                        $display("FAIL capture g=%0d: valid=%b unit=%0d data=%h, required g=%0d unit=%0d data=%h",
                                 g, bus.out_valid, bus.out_unit, bus.out_data, ce.g, ce.u, ce.data);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.cfg_we = 1'b0; bus.pitch_we = 1'b0; bus.ovr_clr = 1'b0;
    endtask

    task automatic random_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #2;
            bus.cfg_we     = ($urandom_range(3) == 0);
            bus.cfg_addr   = AW'($urandom);
            bus.cfg_div    = 18'($urandom);
            bus.cfg_bw     = 3'($urandom);
            bus.pitch_we   = ($urandom_range(3) == 0);
            bus.pitch_addr = AW'($urandom);
            bus.pitch_data = DSZ'({$urandom, $urandom});
            bus.ovr_clr    = ($urandom_range(7) == 0);
        end
        @(posedge clk); #2;
        idle_inputs();
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        idle_inputs();
        bus.cfg_addr = '0; bus.cfg_div = '0; bus.cfg_bw = '0;
        bus.pitch_addr = '0; bus.pitch_data = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Unit 2 gets distinct config and pitch before the first sweep
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_div = 18'h00005; bus.cfg_bw = 3'd3;
        bus.pitch_we = 1'b1; bus.pitch_addr = 2'd2; bus.pitch_data = DSZ'(52'h123);
        @(posedge clk); #2;
        idle_inputs();
        repeat (60) @(posedge clk);

        random_phase(500);
        repeat (10) @(posedge clk);

        // Reset while unit 2 is strobing
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.porta_clk && bus.porta_unit == 2'd2) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_wait: strobe of unit 2 not seen within 200 cycles, required seen");
        end
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.porta_clk || bus.out_valid || bus.busy || bus.porta_unit != '0 || bus.porta_in != '0) begin
            n_fail++;
            $display("FAIL async_reset: clk=%b valid=%b busy=%b unit=%0d in=%h, required all 0",
                     bus.porta_clk, bus.out_valid, bus.busy, bus.porta_unit, bus.porta_in);
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        random_phase(300);
        repeat (60) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (sq.size() != 0 || cq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d strobes and %0d captures outstanding, required 0", sq.size(), cq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
